mastermind_scoreboard: RTL and testbench
========================================

# mastermind_scoreboard

Game-level bookkeeping stage directly downstream of the Mastermind scoring datapath. It consumes one scored guess per round (the 12-bit guess plus its red/white peg counts), counts attempts, and decides win or loss. It keeps a history of every scored guess and drives registered display data for either the latest round or a selected past round. It also tells the control FSM whether further guesses are accepted.

## Interface
Parameters:
- MAX_GUESSES, 8, number of guesses allowed per game; legal range 1..15.
- BLINK_DIV, 25_000_000, clk cycles per half-period of the win blink.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- new_game  in  1  synchronous one-cycle pulse that clears the game.
- score_valid  in  1  one-cycle pulse; guess/red/white are valid this cycle.
- guess  in  12  scored guess, four 3-bit symbols, symbol 1 in [2:0].
- red  in  3  exact-position matches, 0..4.
- white  in  3  colour-only matches, 0..4.
- review_en  in  1  1 = show history entry review_sel; 0 = show latest entry.
- review_sel  in  4  history index to review (0 = first guess).
- accept  out  1  high while state is PLAYING; control gates guess loading on it.
- win  out  1  high in state WON.
- lose  out  1  high in state LOST.
- guess_count  out  4  number of recorded guesses, 0..MAX_GUESSES.
- score_err  out  1  one-cycle pulse when a malformed score is rejected.
- disp_guess  out  12  guess of the displayed entry.
- disp_red  out  3  red count of the displayed entry.
- disp_white  out  3  white count of the displayed entry.
- blink  out  1  win/lose indicator for the display.

## Operation
- States: PLAYING, WON, LOST. Reset and new_game both enter PLAYING.
- History: MAX_GUESSES entries of {guess, red, white}, 18 bits each, written at index guess_count.
- Accepted score: score_valid=1, state PLAYING, red<=4, white<=4, red+white<=4 (use a 4-bit sum). On an accepted score:
  - write the entry at index guess_count;
  - increment guess_count by 1;
  - if red==4, go to WON;
  - else if the new count equals MAX_GUESSES, go to LOST;
  - else stay in PLAYING.
- Win takes priority over loss on the final guess.
- Malformed score while PLAYING: no write, no count change, no state change; score_err pulses for 1 cycle.
- score_valid in WON or LOST: ignored entirely, with no error pulse.
- new_game: guess_count=0, state PLAYING, blink counter cleared. History contents may remain but are unreachable because entries at index >= guess_count display as zero.
- new_game and score_valid in the same cycle: new_game wins and the score is dropped.
- Display select:
  - review_en=0: show entry guess_count-1, or all zeros when guess_count==0.
  - review_en=1: show entry review_sel, or all zeros when review_sel >= guess_count.
- blink behaviour by state:
  - PLAYING: blink=0.
  - LOST: blink=1 constantly.
  - WON: blink toggles every BLINK_DIV cycles, starting at 1 on entry to WON; the divider counter restarts on entry.

## Timing
- Reset values: accept=1, win=0, lose=0, guess_count=0, score_err=0, disp_guess=0, disp_red=0, disp_white=0, blink=0. The state register, count, blink counter and display registers are all reset.
- accept, win and lose decode combinationally from the state register.
- score_valid sampled at edge N: guess_count, state and score_err are valid after edge N.
- disp_* are registered from the post-edge-N count and history, so they are valid after edge N+1 (one-cycle display latency).
- A review_en or review_sel change at edge N is reflected on disp_* after edge N+1.
- Back-to-back score_valid pulses on consecutive cycles are each processed. The second pulse sees the updated count and state.
- Assertion of resetn mid-game takes effect immediately and asynchronously. Release is synchronous to the next edge.

## Test plan
- Reset, then 3 accepted scores (red=1/white=2, red=0/white=0, red=2/white=1) -> guess_count=3, accept=1; with review_en=0, disp shows red=2/white=1 one cycle after the third pulse; review_sel=0 shows the first guess with red=1/white=2.
- Score red=4, white=0 on guess 2 -> win=1, accept=0, blink=1; blink toggles after BLINK_DIV cycles (use BLINK_DIV=4 in sim); a further score_valid leaves guess_count=2.
- MAX_GUESSES=8, eight scores with red<4 -> lose=1 after the 8th, guess_count=8, blink=1; a ninth pulse is ignored with score_err=0.
- 8th score has red=4 -> win=1, lose=0 (win priority).
- Score red=3, white=2 -> score_err pulses 1 cycle, guess_count unchanged; review_sel=5 with guess_count=2 -> disp all zeros.
- new_game coincident with score_valid in WON -> PLAYING, guess_count=0, disp zeros next cycle. resetn pulsed low mid-game -> all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/mastermind_scoreboard.sv
// mastermind_scoreboard
// Game bookkeeping behind the Mastermind scoring datapath: counts scored
// guesses, decides win/loss, keeps a guess history and drives registered
// display data for the latest or a reviewed round.
module mastermind_scoreboard #(
    parameter int unsigned MAX_GUESSES = 8,
    parameter int unsigned BLINK_DIV   = 25_000_000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        new_game,
    input  logic        score_valid,
    input  logic [11:0] guess,
    input  logic [2:0]  red,
    input  logic [2:0]  white,
    input  logic        review_en,
    input  logic [3:0]  review_sel,
    output logic        accept,
    output logic        win,
    output logic        lose,
    output logic [3:0]  guess_count,
    output logic        score_err,
    output logic [11:0] disp_guess,
    output logic [2:0]  disp_red,
    output logic [2:0]  disp_white,
    output logic        blink
);

    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {
        PLAYING,
        WON,
        LOST
    } state_t;

    state_t        state;
    logic [BW-1:0] blink_cnt;
    logic [17:0]   hist [MAX_GUESSES];

    logic [3:0]    rw_sum;
    logic          score_ok;
    logic          do_write;
    logic [3:0]    sel_idx;
    logic          sel_valid;
    logic [17:0]   sel_entry;

    // Status flags decode straight from the state register
    always_comb begin
        accept = (state == PLAYING);
        win    = (state == WON);
        lose   = (state == LOST);
    end

    // Score legality check and history write enable
    always_comb begin
        rw_sum   = {1'b0, red} + {1'b0, white};
        score_ok = (red <= 3'd4) && (white <= 3'd4) && (rw_sum <= 4'd4);
        do_write = score_valid && !new_game && (state == PLAYING) && score_ok;
    end

    // Game state, guess counter, error pulse and blink generator
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= PLAYING;
            guess_count <= '0;
            score_err   <= 1'b0;
            blink       <= 1'b0;
            blink_cnt   <= '0;
        end else begin
            score_err <= 1'b0;
            if (new_game) begin
                state       <= PLAYING;
                guess_count <= '0;
                blink       <= 1'b0;
                blink_cnt   <= '0;
            end else begin
                case (state)
                    PLAYING: begin
                        blink <= 1'b0;
                        if (score_valid) begin
                            if (score_ok) begin
                                guess_count <= guess_count + 4'd1;
                                // win is tested first so a 4-red final guess wins
                                if (red == 3'd4) begin
                                    state     <= WON;
                                    blink     <= 1'b1;
                                    blink_cnt <= '0;
                                end else if (guess_count + 4'd1 == 4'(MAX_GUESSES)) begin
                                    state <= LOST;
                                    blink <= 1'b1;
                                end
                            end else begin
                                score_err <= 1'b1;
                            end
                        end
                    end
                    WON: begin
                        if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                            blink_cnt <= '0;
                            blink     <= ~blink;
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                        end
                    end
                    LOST: begin
                        blink <= 1'b1;
                    end
                    default: begin
                        state <= PLAYING;
                    end
                endcase
            end
        end
    end

    // History storage, written at the current count on an accepted score
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < MAX_GUESSES; i++) begin
            if (do_write && (guess_count == 4'(i))) begin
                hist[i] <= {guess, red, white};
            end
        end
    end

    // Select the displayed entry; entries at or beyond the count read as zero
    always_comb begin
        sel_idx   = review_en ? review_sel : (guess_count - 4'd1);
        sel_valid = review_en ? (review_sel < guess_count) : (guess_count != 4'd0);
        sel_entry = '0;
        for (int unsigned i = 0; i < MAX_GUESSES; i++) begin
            if (sel_idx == 4'(i)) begin
                sel_entry = hist[i];
            end
        end
    end

    // Registered display outputs, one cycle behind count/history
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            disp_guess <= '0;
            disp_red   <= '0;
            disp_white <= '0;
        end else if (sel_valid) begin
            {disp_guess, disp_red, disp_white} <= sel_entry;
        end else begin
            {disp_guess, disp_red, disp_white} <= '0;
        end
    end

endmodule

// File: tb/tb_mastermind_scoreboard.sv
// Scoreboard bench for mastermind_scoreboard: the driver advances a
// game-level reference model and queues the expected post-edge outputs;
// a monitor pops and compares them on the falling edge.
module tb_mastermind_scoreboard;

    localparam int MAXG = 8;
    localparam int BDIV = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        new_game;
    logic        score_valid;
    logic [11:0] guess;
    logic [2:0]  red;
    logic [2:0]  white;
    logic        review_en;
    logic [3:0]  review_sel;
    logic        accept;
    logic        win;
    logic        lose;
    logic [3:0]  guess_count;
    logic        score_err;
    logic [11:0] disp_guess;
    logic [2:0]  disp_red;
    logic [2:0]  disp_white;
    logic        blink;

    mastermind_scoreboard #(
        .MAX_GUESSES(MAXG),
        .BLINK_DIV  (BDIV)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .new_game   (new_game),
        .score_valid(score_valid),
        .guess      (guess),
        .red        (red),
        .white      (white),
        .review_en  (review_en),
        .review_sel (review_sel),
        .accept     (accept),
        .win        (win),
        .lose       (lose),
        .guess_count(guess_count),
        .score_err  (score_err),
        .disp_guess (disp_guess),
        .disp_red   (disp_red),
        .disp_white (disp_white),
        .blink      (blink)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int tgt;
        int cnt;
        bit acc;
        bit wn;
        bit ls;
        bit err;
        bit blk;
        int dg;
        int dr;
        int dw;
    } exp_t;

    exp_t q[$];

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: game described by a round list and two outcome flags
    int m_cnt = 0;
    bit m_won = 0;
    bit m_lost = 0;
    int m_win_cyc = 0;
    int h_g[16];
    int h_r[16];
    int h_w[16];

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_accept", int'(accept), 1);
        chk("rst_win", int'(win), 0);
        chk("rst_lose", int'(lose), 0);
        chk("rst_count", int'(guess_count), 0);
        chk("rst_err", int'(score_err), 0);
        chk("rst_dguess", int'(disp_guess), 0);
        chk("rst_dred", int'(disp_red), 0);
        chk("rst_dwhite", int'(disp_white), 0);
        chk("rst_blink", int'(blink), 0);
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_won  = 0;
        m_lost = 0;
    endtask

    // Drive one cycle of inputs, predict the outputs after the next edge
    task automatic step(input bit ng, input bit sv, input logic [11:0] g,
                        input int r, input int w, input bit ren, input int rsel);
        exp_t e;
        int   idx;
        bit   vld;
        new_game    = ng;
        score_valid = sv;
        guess       = g;
        red         = 3'(r);
        white       = 3'(w);
        review_en   = ren;
        review_sel  = 4'(rsel);
        e.tgt = cyc + 1;
        vld = ren ? (rsel < m_cnt) : (m_cnt > 0);
        idx = ren ? rsel : m_cnt - 1;
        e.dg = vld ? h_g[idx] : 0;
        e.dr = vld ? h_r[idx] : 0;
        e.dw = vld ? h_w[idx] : 0;
        e.err = 0;
        if (ng) begin
            model_reset();
        end else if (sv && !m_won && !m_lost) begin
            if (r <= 4 && w <= 4 && r + w <= 4) begin
                h_g[m_cnt] = int'(g);
                h_r[m_cnt] = r;
                h_w[m_cnt] = w;
                m_cnt++;
                if (r == 4) begin
                    m_won     = 1;
                    m_win_cyc = e.tgt;
                end else if (m_cnt == MAXG) begin
                    m_lost = 1;
                end
            end else begin
                e.err = 1;
            end
        end
        e.cnt = m_cnt;
        e.acc = !m_won && !m_lost;
        e.wn  = m_won;
        e.ls  = m_lost;
        if (m_won)
            e.blk = (((e.tgt - m_win_cyc) / BDIV) % 2) == 0;
        else
            e.blk = m_lost;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit ren, input int rsel);
        step(0, 0, 12'h000, 0, 0, ren, rsel);
    endtask

    task automatic score(input int r, input int w);
        step(0, 1, 12'($urandom), r, w, 0, 0);
    endtask

    // Monitor: compare every queued prediction whose edge has occurred
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].tgt <= cyc) begin
                e = q.pop_front();
                chk("edge", cyc, e.tgt);
                chk("guess_count", int'(guess_count), e.cnt);
                chk("accept", int'(accept), int'(e.acc));
                chk("win", int'(win), int'(e.wn));
                chk("lose", int'(lose), int'(e.ls));
                chk("score_err", int'(score_err), int'(e.err));
                chk("blink", int'(blink), int'(e.blk));
                chk("disp_guess", int'(disp_guess), e.dg);
                chk("disp_red", int'(disp_red), e.dr);
                chk("disp_white", int'(disp_white), e.dw);
            end
        end
    end

    initial begin
        bit ng;
        bit sv;
        int r;
        int w;
        resetn      = 1'b0;
        new_game    = 1'b0;
        score_valid = 1'b0;
        guess       = '0;
        red         = '0;
        white       = '0;
        review_en   = 1'b0;
        review_sel  = '0;
        #12;
        chk_reset_vals();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        model_reset();

        // three legal scores, latest display, then review of the first
        score(1, 2);
        score(0, 0);
        score(2, 1);
        idle(0, 0);
        idle(1, 0);
        idle(1, 2);
        // malformed score, out-of-range review
        score(3, 2);
        step(0, 1, 12'hfff, 5, 0, 0, 0);
        idle(1, 5);
        // win, blink divider, ignored score after win
        score(4, 0);
        for (int i = 0; i < 11; i++) idle(i % 2, i % 5);
        score(1, 1);
        score(7, 7);
        idle(0, 0);
        // new_game with a coincident score while WON
        step(1, 1, 12'h123, 4, 0, 0, 0);
        idle(0, 0);
        idle(1, 0);

        // eight misses -> loss, ninth ignored
        for (int i = 0; i < 8; i++) score(i % 4, 0);
        score(2, 2);
        score(4, 0);
        for (int i = 0; i < 4; i++) idle(1, i + 6);
        step(1, 0, 12'h0, 0, 0, 0, 0);

        // 4 reds on the final guess wins
        for (int i = 0; i < 7; i++) score(3, 1);
        score(4, 0);
        idle(1, 7);
        idle(1, 8);
        step(1, 0, 12'h0, 0, 0, 0, 0);

        // asynchronous reset mid-game
        score(1, 0);
        score(2, 0);
        @(negedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk_reset_vals();
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(0, 0);

        // randomized play
        for (int i = 0; i < 600; i++) begin
            ng = ($urandom_range(0, 39) == 0) || ((m_won || m_lost) && $urandom_range(0, 9) == 0);
            sv = $urandom_range(0, 2) != 0;
            if ($urandom_range(0, 5) == 0) begin
                r = $urandom_range(0, 7);
                w = $urandom_range(0, 7);
            end else begin
                r = ($urandom_range(0, 11) == 0) ? 4 : $urandom_range(0, 3);
                w = $urandom_range(0, 4 - r);
            end
            step(ng, sv, 12'($urandom), r, w, $urandom_range(0, 1) == 1, $urandom_range(0, 15));
        end
        idle(0, 0);
        @(negedge clk);
        #1;
        chk("drain", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
